nucleic_acid_sequencer: RTL

NUCLEIC_ACID_SEQUENCER -- requirements
Module: nucleic_acid_sequencer

---
 rtl/nacid_pkg.sv | 82 ++++++++
 rtl/nucleic_acid_sequencer_peristaltic_phase_gen.sv | 75 +++++++
 rtl/nucleic_acid_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/nacid_pkg.sv
// Shared types and constants for the nucleic-acid sequencer: FSM states,
// valve polarity, and the six-phase peristaltic pump pattern.
package nacid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LYSIS,
        ST_MIX,
        ST_TRAP,
        ST_WASH,
        ST_ELUTE,
        ST_COLLECT,
        ST_FLUSH
    } state_t;

    localparam logic VALVE_OPEN   = 1'b0;
    localparam logic VALVE_CLOSED = 1'b1;

    localparam int         PHASES    = 6;
    localparam logic [2:0] PUMP_IDLE = 3'b111;

    typedef struct packed {
        logic lysis;
        logic wash;
        logic elute;
        logic vertical;
        logic horiz;
        logic loop_exit;
        logic bead_vtl;
        logic bead_trap;
        logic waste;
    } valve_t;

    // Phase pattern table, pump[2:0] for phase index 0..5.
    function automatic logic [2:0] pump_pattern(input logic [2:0] idx);
        logic [2:0] p;
        case (idx)
            3'd0:    p = 3'b011;
            3'd1:    p = 3'b001;
            3'd2:    p = 3'b101;
            3'd3:    p = 3'b100;
            3'd4:    p = 3'b110;
            3'd5:    p = 3'b010;
            default: p = PUMP_IDLE;
        endcase
        return p;
    endfunction

    // Valves opened in each state; everything else stays pressurised.
    function automatic valve_t valves_for(input state_t s);
        valve_t v;
        v = '1;
        case (s)
            ST_LYSIS: begin
                v.lysis    = VALVE_OPEN;
                v.vertical = VALVE_OPEN;
            end
            ST_MIX: begin
                v.horiz     = VALVE_OPEN;
                v.loop_exit = VALVE_OPEN;
            end
            ST_TRAP: v.bead_vtl = VALVE_OPEN;
            ST_WASH, ST_FLUSH: begin
                v.wash     = VALVE_OPEN;
                v.vertical = VALVE_OPEN;
                v.waste    = VALVE_OPEN;
            end
            ST_ELUTE: begin
                v.elute    = VALVE_OPEN;
                v.vertical = VALVE_OPEN;
                v.waste    = VALVE_OPEN;
            end
            ST_COLLECT: begin
                v.elute    = VALVE_OPEN;
                v.vertical = VALVE_OPEN;
            end
            default: v = '1;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/nucleic_acid_sequencer_peristaltic_phase_gen.sv
// Peristaltic pump sequencer: PUMP_DIV divider, phase index and revolution
// count. Pump output is registered and aligned with the FSM state register.
module peristaltic_phase_gen
    import nacid_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int PUMP_DIV = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             active,
    input  logic             hold,
    input  logic [CNT_W-1:0] revs,
    output logic [2:0]       pump,
    output logic             rev_done
);

    logic [7:0]       div_q, div_d;
    logic [2:0]       phase_q, phase_d;
    logic [CNT_W-1:0] rev_q, rev_d;
    logic [2:0]       pump_q, pump_d;
    logic [CNT_W-1:0] rev_target;
    logic             div_wrap, phase_wrap;

    always_comb begin
        rev_target = (revs == '0) ? CNT_W'(1) : revs;
        div_wrap   = (div_q == 8'(PUMP_DIV - 1));
        phase_wrap = (phase_q == 3'(PHASES - 1));
        rev_done   = active && div_wrap && phase_wrap && (rev_q == rev_target - 1'b1);

        div_d   = div_q;
        phase_d = phase_q;
        rev_d   = rev_q;
        pump_d  = pump_q;
        if (!run) begin
            div_d   = '0;
            phase_d = '0;
            rev_d   = '0;
            pump_d  = PUMP_IDLE;
        end else if (!active) begin
            // First MIX cycle: start at phase 0 with a fresh divider.
            div_d   = '0;
            phase_d = '0;
            rev_d   = '0;
            pump_d  = pump_pattern(3'd0);
        end else if (!hold) begin
            if (div_wrap) begin
                div_d   = '0;
                phase_d = phase_wrap ? 3'd0 : phase_q + 3'd1;
                if (phase_wrap) rev_d = rev_q + 1'b1;
                pump_d  = pump_pattern(phase_d);
            end else begin
                div_d = div_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            phase_q <= '0;
            rev_q   <= '0;
            pump_q  <= PUMP_IDLE;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
            rev_q   <= rev_d;
            pump_q  <= pump_d;
        end
    end

    assign pump = pump_q;

endmodule

// File: rtl/nucleic_acid_sequencer.sv
// Protocol FSM for the nucleic-acid extraction reactor: step timing, valves
// and per-channel collection. Optional pause input under NACID_PAUSE_EN.
module nucleic_acid_sequencer
    import nacid_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 16,
    parameter int PUMP_DIV = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
`ifdef NACID_PAUSE_EN
    input  logic             pause,
`endif
    input  logic [CNT_W-1:0] lysis_len,
    input  logic [CNT_W-1:0] mix_revs,
    input  logic [CNT_W-1:0] wash_len,
    input  logic [CNT_W-1:0] elute_len,
    input  logic [CNT_W-1:0] collect_len,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             lysis_ctl,
    output logic             wash_ctl,
    output logic             elute_ctl,
    output logic             vertical_ctl,
    output logic             horiz_ctl,
    output logic             loop_exit_ctl,
    output logic             bead_vtl_ctl,
    output logic             bead_trap_ctl,
    output logic             waste_ctl,
    output logic [2:0]       pump,
    output logic [N_CH-1:0]  collect_ctl,
    output logic [2:0]       state
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    // Bead settling in TRAP has no length input; it lasts one pump revolution period.
    localparam logic [CNT_W-1:0] TRAP_LEN = CNT_W'(PHASES * PUMP_DIV);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic             gap_q, gap_d;
    valve_t           vlv_q, vlv_d;
    logic [N_CH-1:0]  coll_q, coll_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             expire, abort_go, hold, rev_done;

    function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] l);
        return (l == '0) ? CNT_W'(1) : l;
    endfunction

    assign expire   = (cnt_q == CNT_W'(1));
    assign abort_go = abort && (state_q != ST_IDLE) && (state_q != ST_FLUSH);
`ifdef NACID_PAUSE_EN
    assign hold = pause && !abort_go;
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
        ch_d      = ch_q;
        gap_d     = gap_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        if (hold) begin
            cnt_d = cnt_q;
        end else if (abort_go) begin
            state_d = ST_FLUSH;
            cnt_d   = eff_len(wash_len);
            ch_d    = '0;
            gap_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    state_d = ST_LYSIS;
                    cnt_d   = eff_len(lysis_len);
                end
                ST_LYSIS: if (expire) state_d = ST_MIX;
                ST_MIX: if (rev_done) begin
                    state_d = ST_TRAP;
                    cnt_d   = TRAP_LEN;
                end
                ST_TRAP: if (expire) begin
                    state_d = ST_WASH;
                    cnt_d   = eff_len(wash_len);
                end
                ST_WASH: if (expire) begin
                    state_d = ST_ELUTE;
                    cnt_d   = eff_len(elute_len);
                end
                ST_ELUTE: if (expire) begin
                    state_d = ST_COLLECT;
                    cnt_d   = eff_len(collect_len);
                    ch_d    = '0;
                    gap_d   = 1'b0;
                end
                ST_COLLECT: begin
                    // One all-closed cycle separates consecutive channels.
                    if (gap_q) begin
                        gap_d = 1'b0;
                        ch_d  = ch_q + 1'b1;
                        cnt_d = eff_len(collect_len);
                    end else if (expire) begin
                        if (ch_q == CH_W'(N_CH - 1)) begin
                            state_d = ST_IDLE;
                            ch_d    = '0;
                            done_d  = 1'b1;
                        end else begin
                            gap_d = 1'b1;
                        end
                    end
                end
                ST_FLUSH: if (expire) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        vlv_d  = valves_for(state_d);
        coll_d = '1;
        if (state_d == ST_COLLECT && !gap_d) coll_d[ch_d] = VALVE_OPEN;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ch_q      <= '0;
            gap_q     <= 1'b0;
            vlv_q     <= '1;
            coll_q    <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            gap_q     <= gap_d;
            vlv_q     <= vlv_d;
            coll_q    <= coll_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    peristaltic_phase_gen #(
        .CNT_W    (CNT_W),
        .PUMP_DIV (PUMP_DIV)
    ) u_pump (
        .clk      (clk),
        .rst      (rst),
        .run      (state_d == ST_MIX),
        .active   (state_q == ST_MIX),
        .hold     (hold),
        .revs     (mix_revs),
        .pump     (pump),
        .rev_done (rev_done)
    );

    assign busy          = busy_q;
    assign done          = done_q;
    assign aborted       = aborted_q;
    assign lysis_ctl     = vlv_q.lysis;
    assign wash_ctl      = vlv_q.wash;
    assign elute_ctl     = vlv_q.elute;
    assign vertical_ctl  = vlv_q.vertical;
    assign horiz_ctl     = vlv_q.horiz;
    assign loop_exit_ctl = vlv_q.loop_exit;
    assign bead_vtl_ctl  = vlv_q.bead_vtl;
    assign bead_trap_ctl = vlv_q.bead_trap;
    assign waste_ctl     = vlv_q.waste;
    assign collect_ctl   = coll_q;
    assign state         = state_q;

endmodule
